// File: rtl/ip_psram_arbiter_if.sv
// Single-byte request/response port between one client and the PSRAM arbiter.
// The client drives the master side and the arbiter implements the slave side.
interface ip_psram_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] address;
  logic [7:0]        wdata;
  logic              ready;
  logic [7:0]        rdata;
  logic              rdata_en;

  modport master (output rd, wr, address, wdata, input ready, rdata, rdata_en);
  modport slave  (input rd, wr, address, wdata, output ready, rdata, rdata_en);
endinterface

// File: rtl/ip_psram_arbiter.sv
// Two-client round-robin arbiter with one-entry holding slots in front of a
// single-operation PSRAM controller port; read data is routed back to its issuer.
module ip_psram_arbiter #(
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              initial_busy,
  ip_psram_arbiter_if.slave a,
  ip_psram_arbiter_if.slave b,
  output logic              rd,
  output logic              wr,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        wdata,
  input  logic              busy,
  input  logic [7:0]        rdata,
  input  logic              rdata_en
);

  typedef enum logic [1:0] {IDLE, GUARD, WAIT_DONE} state_t;

  typedef struct packed {
    logic              full;
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } slot_t;

  state_t state, state_nx;
  slot_t  slot_a, slot_b, sel;
  logic   last_b;   // last grant went to client B
  logic   own_b;    // owner of the operation in flight
  logic   own_wr;   // kind of the operation in flight
  logic   issue, grant_b, done_rd;

  // Capture only into an empty slot; a slot granted this cycle is drained.
  function automatic slot_t slot_update(input slot_t cur, input logic req_rd,
                                        input logic req_wr,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [7:0] data, input logic take);
    slot_t nx;
    nx = cur;
    if (!cur.full) begin
      if (req_rd || req_wr) begin
        nx.full  = 1'b1;
        nx.is_wr = req_wr;
        nx.addr  = addr;
        nx.data  = req_wr ? data : 8'h00;
      end
    end else if (take) begin
      nx.full = 1'b0;
    end
    return nx;
  endfunction

  assign a.ready = !slot_a.full;
  assign b.ready = !slot_b.full;
  assign sel     = grant_b ? slot_b : slot_a;

  always_ff @(posedge clk) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_nx = state;
    case (state)
      IDLE:      if (issue) state_nx = GUARD;
      GUARD:     state_nx = WAIT_DONE;
      WAIT_DONE: if (own_wr ? !busy : rdata_en) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    issue   = 1'b0;
    grant_b = 1'b0;
    done_rd = 1'b0;
    case (state)
      IDLE: begin
        if ((slot_a.full || slot_b.full) && !busy && !initial_busy) begin
          issue   = 1'b1;
          grant_b = slot_b.full && (!slot_a.full || !last_b);
        end
      end
      WAIT_DONE: done_rd = !own_wr && rdata_en;
      default: ;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignment so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rd         <= 1'b0;
      wr         <= 1'b0;
      address    <= '0;
      wdata      <= '0;
      own_b      <= 1'b0;
      own_wr     <= 1'b0;
      last_b     <= 1'b1;
      slot_a     <= '0;
      slot_b     <= '0;
      a.rdata    <= '0;
      b.rdata    <= '0;
      a.rdata_en <= 1'b0;
      b.rdata_en <= 1'b0;
    end else begin
      rd         <= 1'b0;
      wr         <= 1'b0;
      a.rdata_en <= 1'b0;
      b.rdata_en <= 1'b0;
      if (issue) begin
        rd      <= !sel.is_wr;
        wr      <= sel.is_wr;
        address <= sel.addr;
        wdata   <= sel.data;
        own_b   <= grant_b;
        own_wr  <= sel.is_wr;
        last_b  <= grant_b;
      end
      if (done_rd) begin
        if (own_b) begin
          b.rdata    <= rdata;
          b.rdata_en <= 1'b1;
        end else begin
          a.rdata    <= rdata;
          a.rdata_en <= 1'b1;
        end
      end
      slot_a <= slot_update(slot_a, a.rd, a.wr, a.address, a.wdata, issue && !grant_b);
      slot_b <= slot_update(slot_b, b.rd, b.wr, b.address, b.wdata, issue && grant_b);
    end
  end

endmodule

// File: tb/tb_ip_psram_arbiter.sv
// Directed bench for ip_psram_arbiter: a behavioural controller model plus
// scoreboard queues for port operations and per-client read returns.
module tb_ip_psram_arbiter;
  localparam int ADDR_W = 22;

  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } op_t;

  logic              clk = 1'b0;
  logic              n_reset;
  logic              initial_busy;
  logic              rd, wr;
  logic [ADDR_W-1:0] address;
  logic [7:0]        wdata;
  logic              busy;
  logic [7:0]        rdata;
  logic              rdata_en;

  // Controller model outputs and stimulus overrides
  logic       m_busy = 1'b0, m_rdata_en = 1'b0, m_pend_rd = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  int         m_cnt = 0;
  int         ctl_hold = 3;
  logic [7:0] ctl_rdata = 8'h00;
  logic       f_busy = 1'b0, f_rdata_en = 1'b0;
  logic [7:0] f_rdata = 8'h00;
  logic       busy_prev = 1'b0, ib_prev = 1'b0;

  op_t        port_q[$];
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  op_t        cur_op;
  int         port_ops = 0, a_rets = 0, b_rets = 0;
  int         n_checks = 0, n_fail = 0;

  ip_psram_arbiter_if #(.ADDR_W(ADDR_W)) a_if ();
  ip_psram_arbiter_if #(.ADDR_W(ADDR_W)) b_if ();

  ip_psram_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .n_reset(n_reset), .initial_busy(initial_busy),
    .a(a_if), .b(b_if),
    .rd(rd), .wr(wr), .address(address), .wdata(wdata),
    .busy(busy), .rdata(rdata), .rdata_en(rdata_en)
  );

  always #5 clk = ~clk;

  assign busy     = m_busy | f_busy;
  assign rdata_en = m_rdata_en | f_rdata_en;
  assign rdata    = f_rdata_en ? f_rdata : m_rdata;

  // Controller: busy for ctl_hold cycles after a request; reads end with rdata_en.
  always @(posedge clk) begin
    m_rdata_en <= 1'b0;
    busy_prev  <= busy;
    ib_prev    <= initial_busy;
    if (rd || wr) begin
      m_busy    <= 1'b1;
      m_cnt     <= ctl_hold;
      m_pend_rd <= rd;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        if (m_pend_rd) begin
          m_rdata_en <= 1'b1;
          m_rdata    <= ctl_rdata;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Port scoreboard
  always @(negedge clk) begin
    if (rd || wr) begin
      port_ops++;
      check("issue_while_busy", {30'd0, busy_prev, ib_prev}, 32'd0);
      if (port_q.size() == 0) begin
        check("port_unexpected_op", 32'd1, 32'd0);
      end else begin
        cur_op = port_q.pop_front();
        check("port_kind", {30'd0, rd, wr}, cur_op.is_wr ? 32'd1 : 32'd2);
        check("port_address", 32'(address), 32'(cur_op.addr));
        if (cur_op.is_wr) check("port_wdata", 32'(wdata), 32'(cur_op.data));
      end
    end
  end

  // Read-return scoreboards
  always @(negedge clk) begin
    if (a_if.rdata_en) begin
      a_rets++;
      if (a_q.size() == 0) check("a_unexpected_rdata_en", 32'd1, 32'd0);
      else check("a_rdata", 32'(a_if.rdata), 32'(a_q.pop_front()));
    end
    if (b_if.rdata_en) begin
      b_rets++;
      if (b_q.size() == 0) check("b_unexpected_rdata_en", 32'd1, 32'd0);
      else check("b_rdata", 32'(b_if.rdata), 32'(b_q.pop_front()));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic req(input bit to_b, input bit is_wr, input logic [ADDR_W-1:0] addr,
                     input logic [7:0] data);
    tick();
    if (to_b) begin
      b_if.rd = !is_wr; b_if.wr = is_wr; b_if.address = addr; b_if.wdata = data;
    end else begin
      a_if.rd = !is_wr; a_if.wr = is_wr; a_if.address = addr; a_if.wdata = data;
    end
    tick();
    a_if.rd = 1'b0; a_if.wr = 1'b0; b_if.rd = 1'b0; b_if.wr = 1'b0;
  endtask

  task automatic expect_op(input bit is_wr, input logic [ADDR_W-1:0] addr, input logic [7:0] data);
    op_t o;
    o.is_wr = is_wr; o.addr = addr; o.data = data;
    port_q.push_back(o);
  endtask

  task automatic wait_ops(input int target, input int budget);
    int n = 0;
    while (port_ops < target && n < budget) begin tick(); n++; end
    check("wait_ops_timeout", {31'd0, port_ops >= target}, 32'd1);
  endtask

  task automatic wait_a_rets(input int target, input int budget);
    int n = 0;
    while (a_rets < target && n < budget) begin tick(); n++; end
    check("wait_a_rdata_timeout", {31'd0, a_rets >= target}, 32'd1);
  endtask

  task automatic wait_b_rets(input int target, input int budget);
    int n = 0;
    while (b_rets < target && n < budget) begin tick(); n++; end
    check("wait_b_rdata_timeout", {31'd0, b_rets >= target}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_wr"}, {30'd0, rd, wr}, 32'd0);
    check({tag, "_address"}, 32'(address), 32'd0);
    check({tag, "_wdata"}, 32'(wdata), 32'd0);
    check({tag, "_ready"}, {30'd0, a_if.ready, b_if.ready}, 32'd3);
    check({tag, "_a_rdata"}, 32'(a_if.rdata), 32'd0);
    check({tag, "_b_rdata"}, 32'(b_if.rdata), 32'd0);
    check({tag, "_rdata_en"}, {30'd0, a_if.rdata_en, b_if.rdata_en}, 32'd0);
  endtask

  initial begin
    int ops0;
    n_reset = 1'b0; initial_busy = 1'b1;
    a_if.rd = 1'b0; a_if.wr = 1'b0; a_if.address = '0; a_if.wdata = '0;
    b_if.rd = 1'b0; b_if.wr = 1'b0; b_if.address = '0; b_if.wdata = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    n_reset = 1'b1;

    // Held by initial_busy, then released
    expect_op(1'b1, 22'h01E240, 8'h5A);
    req(1'b0, 1'b1, 22'h01E240, 8'h5A);
    check("ib_a_ready_low", 32'(a_if.ready), 32'd0);
    repeat (5) tick();
    check("ib_no_issue", 32'(port_ops), 32'd0);
    initial_busy = 1'b0;
    wait_ops(1, 10);
    check("ib_a_ready_back", 32'(a_if.ready), 32'd1);
    repeat (8) tick();
    check("address_held", 32'(address), 32'h01E240);

    // Single read by B
    ctl_rdata = 8'hC3;
    expect_op(1'b0, 22'h039447, 8'h00);
    b_q.push_back(8'hC3);
    req(1'b1, 1'b0, 22'h039447, 8'h00);
    wait_b_rets(1, 20);
    check("b_rdata_held", 32'(b_if.rdata), 32'hC3);
    repeat (3) tick();

    // Reset, then simultaneous requests: A wins first
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    check("b_rdata_cleared", 32'(b_if.rdata), 32'd0);
    ctl_rdata = 8'h96;
    ops0 = port_ops;
    expect_op(1'b0, 22'h054642, 8'h00);
    expect_op(1'b1, 22'h000010, 8'h77);
    a_q.push_back(8'h96);
    tick();
    a_if.rd = 1'b1; a_if.address = 22'h054642;
    b_if.wr = 1'b1; b_if.address = 22'h000010; b_if.wdata = 8'h77;
    tick();
    a_if.rd = 1'b0; b_if.wr = 1'b0;
    check("both_captured", {30'd0, a_if.ready, b_if.ready}, 32'd0);
    tick();
    check("a_issued_b_pending", {30'd0, a_if.ready, b_if.ready}, 32'd2);
    wait_a_rets(1, 20);
    check("b_waits_for_a_rdata", 32'(port_ops), 32'(ops0 + 1));
    wait_ops(ops0 + 2, 10);
    repeat (6) tick();

    // Back-pressure and long busy
    f_busy = 1'b1;
    ops0 = port_ops;
    expect_op(1'b1, 22'h0ABCDE, 8'h11);
    req(1'b0, 1'b1, 22'h0ABCDE, 8'h11);
    req(1'b0, 1'b1, 22'h000FFF, 8'h22);
    check("bp_ready_low", 32'(a_if.ready), 32'd0);
    repeat (3) tick();
    check("bp_no_issue", 32'(port_ops), 32'(ops0));
    ctl_hold = 20;
    f_busy = 1'b0;
    wait_ops(ops0 + 1, 10);
    expect_op(1'b1, 22'h123456, 8'h33);
    req(1'b0, 1'b1, 22'h123456, 8'h33);
    repeat (12) tick();
    check("long_busy_no_issue", 32'(port_ops), 32'(ops0 + 1));
    wait_ops(ops0 + 2, 30);
    repeat (25) tick();
    ctl_hold = 3;

    // Spurious rdata_en in IDLE
    f_rdata = 8'hEE;
    f_rdata_en = 1'b1;
    tick();
    f_rdata_en = 1'b0;
    repeat (2) tick();
    check("spurious_a_rdata", 32'(a_if.rdata), 32'h96);
    check("spurious_b_rdata", 32'(b_if.rdata), 32'h00);

    // Reset during WAIT_DONE of a read
    ctl_hold = 10;
    ctl_rdata = 8'h5C;
    ops0 = port_ops;
    expect_op(1'b0, 22'h00AAAA, 8'h00);
    req(1'b0, 1'b0, 22'h00AAAA, 8'h00);
    wait_ops(ops0 + 1, 10);
    req(1'b1, 1'b1, 22'h3FFFFF, 8'h99);
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    check_reset_outputs("midop_reset");
    repeat (15) tick();
    check("midop_pending_discarded", 32'(port_ops), 32'(ops0 + 1));
    check_reset_outputs("midop_after");

    check("port_q_drained", 32'(port_q.size()), 32'd0);
    check("a_q_drained", 32'(a_q.size()), 32'd0);
    check("b_q_drained", 32'(b_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
